// File: rtl/board_ram_ctrl.sv
// board_ram_ctrl: multi-board cell memory for the warships game.
// One RAM holds N_BOARDS boards of X_SIZE x Y_SIZE cells. Port A is a
// req/ack read/write port with range checking. Port B is a free-running
// read port for the draw pipeline. A sweep sequencer zeroes the whole RAM
// after reset, or a single board on request. The array itself has no reset
// so that it can map onto block RAM.
module board_ram_ctrl #(
  parameter int unsigned N_BOARDS     = 32'd2,
  parameter int unsigned X_SIZE       = 32'd12,
  parameter int unsigned Y_SIZE       = 32'd12,
  parameter int unsigned X_ADDR_WIDTH = 32'd4,
  parameter int unsigned Y_ADDR_WIDTH = 32'd4,
  parameter int unsigned B_ADDR_WIDTH = 32'd1,
  parameter int unsigned DATA_WIDTH   = 32'd2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_req,
  input  logic [B_ADDR_WIDTH-1:0] clear_board,
  output logic                    busy,
  output logic                    clear_done,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [B_ADDR_WIDTH-1:0] a_board,
  input  logic [X_ADDR_WIDTH-1:0] a_x,
  input  logic [Y_ADDR_WIDTH-1:0] a_y,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic                    a_ack,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_err,
  input  logic [B_ADDR_WIDTH-1:0] b_board,
  input  logic [X_ADDR_WIDTH-1:0] b_x,
  input  logic [Y_ADDR_WIDTH-1:0] b_y,
  output logic [DATA_WIDTH-1:0]   b_rdata
);

  localparam int unsigned CELLS_PER_BOARD = X_SIZE * Y_SIZE;
  localparam int unsigned DEPTH           = N_BOARDS * CELLS_PER_BOARD;
  localparam int unsigned IDX_W           = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;

  localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] LAST_CELL  = IDX_W'(DEPTH - 32'd1);
  localparam logic [IDX_W-1:0] BOARD_SPAN = IDX_W'(CELLS_PER_BOARD - 32'd1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_CLEAR_ALL   = 2'd1,
    ST_CLEAR_BOARD = 2'd2
  } state_e;

  // Linear cell index; every term is widened to the full index width
  // before multiplying so nothing is truncated ahead of the final sum.
  function automatic logic [IDX_W-1:0] cell_index(
    input logic [B_ADDR_WIDTH-1:0] board,
    input logic [X_ADDR_WIDTH-1:0] x,
    input logic [Y_ADDR_WIDTH-1:0] y
  );
    logic [IDX_W-1:0] board_w;
    logic [IDX_W-1:0] x_w;
    logic [IDX_W-1:0] y_w;
    board_w = IDX_W'(board);
    x_w     = IDX_W'(x);
    y_w     = IDX_W'(y);
    return (board_w * IDX_W'(CELLS_PER_BOARD)) + (y_w * IDX_W'(X_SIZE)) + x_w;
  endfunction

  // True when the coordinate names a real cell of a real board.
  function automatic logic addr_in_range(
    input logic [B_ADDR_WIDTH-1:0] board,
    input logic [X_ADDR_WIDTH-1:0] x,
    input logic [Y_ADDR_WIDTH-1:0] y
  );
    return (32'(x) < X_SIZE) && (32'(y) < Y_SIZE) && (32'(board) < N_BOARDS);
  endfunction

  // Sweep sequencer state
  state_e           state_q;
  logic [IDX_W-1:0] clr_ptr_q;
  logic [IDX_W-1:0] clr_last_q;
  logic             busy_q;
  logic             clear_done_q;

  // Port A / port B qualifier registers
  logic             a_ack_q;
  logic             a_err_q;
  logic             a_rd_ok_q;
  logic             b_ok_q;

  // RAM and its raw read registers (no reset, BRAM friendly)
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] a_raw_q;
  logic [DATA_WIDTH-1:0] b_raw_q;

  // Combinational helpers
  logic [IDX_W-1:0]      a_idx_s;
  logic                  a_in_range_s;
  logic [IDX_W-1:0]      b_idx_s;
  logic                  b_in_range_s;
  logic [IDX_W-1:0]      clr_base_s;
  logic                  clr_board_ok_s;
  logic                  sweeping_s;
  logic                  a_accept_s;
  logic                  ram_we_s;
  logic [IDX_W-1:0]      ram_addr_s;
  logic [DATA_WIDTH-1:0] ram_wdata_s;

  // Address decode for both ports and for the clear request.
  always_comb begin
    a_idx_s        = cell_index(a_board, a_x, a_y);
    a_in_range_s   = addr_in_range(a_board, a_x, a_y);
    b_idx_s        = cell_index(b_board, b_x, b_y);
    b_in_range_s   = addr_in_range(b_board, b_x, b_y);
    clr_base_s     = cell_index(clear_board, {X_ADDR_WIDTH{1'b0}}, {Y_ADDR_WIDTH{1'b0}});
    clr_board_ok_s = (32'(clear_board) < N_BOARDS);
  end

  // Shared RAM port: the sweep owns it while clearing, port A otherwise.
  // A clear request in the same cycle blocks port A, and no access is
  // accepted in the cycle its ack is showing.
  always_comb begin
    sweeping_s  = (state_q != ST_IDLE);
    a_accept_s  = 1'b0;
    ram_we_s    = 1'b0;
    ram_addr_s  = a_idx_s;
    ram_wdata_s = a_wdata;
    if (sweeping_s) begin
      ram_we_s    = 1'b1;
      ram_addr_s  = clr_ptr_q;
      ram_wdata_s = DATA_ZERO;
    end else begin
      a_accept_s = a_req & ~clear_req & ~a_ack_q;
      ram_we_s   = a_accept_s & a_we & a_in_range_s;
    end
  end

  // Sweep sequencer: walks clr_ptr_q up to clr_last_q writing zeros, then idles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CLEAR_ALL;
      clr_ptr_q    <= IDX_ZERO;
      clr_last_q   <= LAST_CELL;
      busy_q       <= 1'b1;
      clear_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          clear_done_q <= 1'b0;
          if (clear_req && clr_board_ok_s) begin
            state_q    <= ST_CLEAR_BOARD;
            clr_ptr_q  <= clr_base_s;
            clr_last_q <= clr_base_s + BOARD_SPAN;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
          end
        end
        ST_CLEAR_ALL, ST_CLEAR_BOARD: begin
          if (clr_ptr_q == clr_last_q) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b1;
          end else begin
            clr_ptr_q    <= clr_ptr_q + IDX_ONE;
            busy_q       <= 1'b1;
            clear_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_CLEAR_ALL;
          clr_ptr_q    <= IDX_ZERO;
          clr_last_q   <= LAST_CELL;
          busy_q       <= 1'b1;
          clear_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Port A handshake and result qualifiers, port B range qualifier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_ack_q   <= 1'b0;
      a_err_q   <= 1'b0;
      a_rd_ok_q <= 1'b0;
      b_ok_q    <= 1'b0;
    end else begin
      a_ack_q   <= a_accept_s;
      a_err_q   <= a_accept_s & ~a_in_range_s;
      a_rd_ok_q <= a_accept_s & a_in_range_s & ~a_we;
      b_ok_q    <= b_in_range_s;
    end
  end

  // Cell array: one read/write port plus one read-only port, both read-first.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_q[ram_addr_s] <= ram_wdata_s;
    end
    a_raw_q <= mem_q[ram_addr_s];
    b_raw_q <= mem_q[b_idx_s];
  end

  assign busy       = busy_q;
  assign clear_done = clear_done_q;
  assign a_ack      = a_ack_q;
  assign a_err      = a_err_q;
  assign a_rdata    = a_rd_ok_q ? a_raw_q : DATA_ZERO;
  assign b_rdata    = b_ok_q ? b_raw_q : DATA_ZERO;

endmodule
